// File: rtl/numberle_pkg.sv
// Shared types and constants for the Numberle guessing-game controller.
package numberle_pkg;

    localparam int         DIGIT_W   = 4;
    localparam logic [3:0] BLANK     = 4'hF;
    localparam logic [3:0] LOST_CODE = 4'hE;

    typedef enum logic [2:0] {
        ST_ENTRY    = 3'd0,
        ST_COMPARE  = 3'd1,
        ST_FEEDBACK = 3'd2,
        ST_WON      = 3'd3,
        ST_LOST     = 3'd4
    } state_t;

    // Per-digit feedback triple: {guess high, equal, guess low}.
    function automatic logic [2:0] digit_cmp(input logic [DIGIT_W-1:0] guess_d,
                                             input logic [DIGIT_W-1:0] secret_d);
        return {(guess_d > secret_d), (guess_d == secret_d), (guess_d < secret_d)};
    endfunction

endpackage

// File: rtl/numberle_game_ctrl_if.sv
// Keypad/button inputs and display/feedback outputs of the game controller.
interface numberle_game_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    key_valid;
    logic [3:0]              key_val;
    logic                    btn_next;
    logic                    btn_submit;
    logic                    btn_clear;
    logic [4*NUM_DIGITS-1:0] secret;
    logic [NUM_DIGITS-1:0]   anode;
    logic [3:0]              hex_out;
    logic                    dp;
    logic [3*NUM_DIGITS-1:0] led;
    logic [3:0]              tries_used;
    logic                    won;
    logic                    lost;

    modport master (
        output key_valid, key_val, btn_next, btn_submit, btn_clear, secret,
        input  anode, hex_out, dp, led, tries_used, won, lost
    );

    modport slave (
        input  key_valid, key_val, btn_next, btn_submit, btn_clear, secret,
        output anode, hex_out, dp, led, tries_used, won, lost
    );

endinterface

// File: rtl/numberle_scan_mux.sv
// Display multiplexing: dwell counter, position index and active-low anode.
module numberle_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000,
    localparam int IDX_W     = $clog2(NUM_DIGITS)
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [IDX_W-1:0]      idx_next,
    output logic [NUM_DIGITS-1:0] anode
);
    localparam int               CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic [IDX_W-1:0]      idx_r;
    logic [IDX_W-1:0]      idx_nxt_s;
    logic [NUM_DIGITS-1:0] anode_r;

    // Next dwell count and position; index steps only when the dwell wraps.
    always_comb begin
        cnt_nxt_s = cnt_r;
        idx_nxt_s = idx_r;
        if (cnt_r == CNT_LAST) begin
            cnt_nxt_s = {CNT_W{1'b0}};
            if (idx_r == IDX_LAST) begin
                idx_nxt_s = {IDX_W{1'b0}};
            end else begin
                idx_nxt_s = idx_r + IDX_W'(1);
            end
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
            idx_nxt_s = idx_r;
        end
    end

    // Anode is registered from the next index so it stays aligned with idx_r.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            anode_r <= ~NUM_DIGITS'(1);
        end else begin
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
            anode_r <= ~(NUM_DIGITS'(1) << idx_nxt_s);
        end
    end

    assign idx_next = idx_nxt_s;
    assign anode    = anode_r;

endmodule

// File: rtl/numberle_game_ctrl.sv
// Numberle game controller: guess entry, per-digit compare, win/loss tracking
// and registered multiplexed display.
module numberle_game_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int MAX_TRIES  = 7,
    parameter int SCAN_DIV   = 100000
) (
    input  logic                clock,
    input  logic                reset,
    numberle_game_ctrl_if.slave bus
);
    import numberle_pkg::*;

    localparam int               IDX_W    = $clog2(NUM_DIGITS);
    localparam int               LED_W    = 3 * NUM_DIGITS;
    localparam logic [3:0]       MAX_T    = 4'(MAX_TRIES);
    localparam logic [IDX_W-1:0] POS_LAST = IDX_W'(NUM_DIGITS - 1);

    state_t                              state_r, state_nxt_s;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  guess_r, guess_nxt_s;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  secret_r, secret_nxt_s;
    logic [IDX_W-1:0]                    cursor_r, cursor_nxt_s;
    logic [3:0]                          tries_r, tries_nxt_s, tries_inc_s;
    logic [LED_W-1:0]                    led_r, led_nxt_s, cmp_led_s;
    logic                                won_r, won_nxt_s, lost_r, lost_nxt_s;
    logic                                all_eq_s, has_blank_s;
    logic [IDX_W-1:0]                    scan_idx_s;
    logic [NUM_DIGITS-1:0]               anode_s;
    logic [3:0]                          hex_r, hex_nxt_s;
    logic                                dp_r, dp_nxt_s;

    numberle_scan_mux #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) u_scan (
        .clock    (clock),
        .reset    (reset),
        .idx_next (scan_idx_s),
        .anode    (anode_s)
    );

    // Digit-wise comparison of the held guess against the live secret.
    always_comb begin
        cmp_led_s   = {LED_W{1'b0}};
        all_eq_s    = 1'b1;
        has_blank_s = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            cmp_led_s[3*i +: 3] = digit_cmp(guess_r[i], bus.secret[4*i +: 4]);
            all_eq_s    = all_eq_s & (guess_r[i] == bus.secret[4*i +: 4]);
            has_blank_s = has_blank_s | (guess_r[i] == BLANK);
        end
        tries_inc_s = tries_r + 4'd1;
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_ENTRY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; btn_clear overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        if (bus.btn_clear) begin
            state_nxt_s = ST_ENTRY;
        end else begin
            case (state_r)
                ST_ENTRY: begin
                    if (bus.btn_submit && !has_blank_s) begin
                        state_nxt_s = ST_COMPARE;
                    end else begin
                        state_nxt_s = ST_ENTRY;
                    end
                end
                ST_COMPARE: begin
                    if (all_eq_s) begin
                        state_nxt_s = ST_WON;
                    end else if (tries_inc_s == MAX_T) begin
                        state_nxt_s = ST_LOST;
                    end else begin
                        state_nxt_s = ST_FEEDBACK;
                    end
                end
                ST_FEEDBACK: begin
                    if (bus.btn_submit) begin
                        state_nxt_s = ST_ENTRY;
                    end else begin
                        state_nxt_s = ST_FEEDBACK;
                    end
                end
                ST_WON:  state_nxt_s = ST_WON;
                ST_LOST: state_nxt_s = ST_LOST;
                default: state_nxt_s = ST_ENTRY;
            endcase
        end
    end

    // FSM outputs: next values of the game datapath.
    always_comb begin
        guess_nxt_s  = guess_r;
        secret_nxt_s = secret_r;
        cursor_nxt_s = cursor_r;
        tries_nxt_s  = tries_r;
        led_nxt_s    = led_r;
        won_nxt_s    = won_r;
        lost_nxt_s   = lost_r;
        if (bus.btn_clear) begin
            guess_nxt_s  = {NUM_DIGITS{BLANK}};
            cursor_nxt_s = {IDX_W{1'b0}};
            tries_nxt_s  = 4'd0;
            led_nxt_s    = {LED_W{1'b0}};
            won_nxt_s    = 1'b0;
            lost_nxt_s   = 1'b0;
        end else begin
            case (state_r)
                ST_ENTRY: begin
                    // Write lands at the current cursor before it advances.
                    if (bus.key_valid && (bus.key_val <= 4'd9)) begin
                        guess_nxt_s[cursor_r] = bus.key_val;
                    end else begin
                        guess_nxt_s = guess_r;
                    end
                    if (bus.btn_next) begin
                        cursor_nxt_s = (cursor_r == POS_LAST) ? {IDX_W{1'b0}}
                                                              : cursor_r + IDX_W'(1);
                    end else begin
                        cursor_nxt_s = cursor_r;
                    end
                end
                ST_COMPARE: begin
                    tries_nxt_s  = tries_inc_s;
                    secret_nxt_s = bus.secret;
                    led_nxt_s    = all_eq_s ? {LED_W{1'b1}} : cmp_led_s;
                    won_nxt_s    = all_eq_s;
                    lost_nxt_s   = !all_eq_s && (tries_inc_s == MAX_T);
                end
                ST_FEEDBACK: begin
                    if (bus.btn_submit) begin
                        guess_nxt_s  = {NUM_DIGITS{BLANK}};
                        cursor_nxt_s = {IDX_W{1'b0}};
                    end else begin
                        guess_nxt_s  = guess_r;
                        cursor_nxt_s = cursor_r;
                    end
                end
                default: begin
                    guess_nxt_s = guess_r;
                end
            endcase
        end
    end

    // Game datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            guess_r  <= {NUM_DIGITS{BLANK}};
            secret_r <= {NUM_DIGITS{BLANK}};
            cursor_r <= {IDX_W{1'b0}};
            tries_r  <= 4'd0;
            led_r    <= {LED_W{1'b0}};
            won_r    <= 1'b0;
            lost_r   <= 1'b0;
        end else begin
            guess_r  <= guess_nxt_s;
            secret_r <= secret_nxt_s;
            cursor_r <= cursor_nxt_s;
            tries_r  <= tries_nxt_s;
            led_r    <= led_nxt_s;
            won_r    <= won_nxt_s;
            lost_r   <= lost_nxt_s;
        end
    end

    // Display content for the position that the anode is about to enable.
    always_comb begin
        hex_nxt_s = BLANK;
        dp_nxt_s  = 1'b1;
        case (state_r)
            ST_ENTRY, ST_COMPARE: begin
                hex_nxt_s = guess_r[scan_idx_s];
                dp_nxt_s  = (scan_idx_s == cursor_r) ? 1'b0 : 1'b1;
            end
            ST_FEEDBACK: begin
                hex_nxt_s = (scan_idx_s == {IDX_W{1'b0}}) ? (MAX_T - tries_r) : BLANK;
            end
            ST_WON:  hex_nxt_s = secret_r[scan_idx_s];
            ST_LOST: hex_nxt_s = LOST_CODE;
            default: hex_nxt_s = BLANK;
        endcase
    end

    // Display registers; reset shows a blank position 0 with the cursor dot.
    always_ff @(posedge clock) begin
        if (reset) begin
            hex_r <= BLANK;
            dp_r  <= 1'b0;
        end else begin
            hex_r <= hex_nxt_s;
            dp_r  <= dp_nxt_s;
        end
    end

    assign bus.anode      = anode_s;
    assign bus.hex_out    = hex_r;
    assign bus.dp         = dp_r;
    assign bus.led        = led_r;
    assign bus.tries_used = tries_r;
    assign bus.won        = won_r;
    assign bus.lost       = lost_r;

endmodule

// File: tb/tb_numberle_game_ctrl.sv
// Two controllers (MAX_TRIES 7 and 2) share one stimulus stream and are
// checked every cycle against a game-rule reference model.
module tb_numberle_game_ctrl;
    localparam int N  = 4;
    localparam int SD = 4;
    localparam int S_ENTRY = 0, S_COMPARE = 1, S_FEEDBACK = 2, S_WON = 3, S_LOST = 4;

    logic        clock      = 1'b0;
    logic        reset      = 1'b1;
    logic        key_valid  = 1'b0;
    logic [3:0]  key_val    = 4'd0;
    logic        btn_next   = 1'b0;
    logic        btn_submit = 1'b0;
    logic        btn_clear  = 1'b0;
    logic [15:0] secret     = 16'h0000;

    always #5 clock = ~clock;

    numberle_game_ctrl_if #(.NUM_DIGITS(N)) if_a ();
    numberle_game_ctrl_if #(.NUM_DIGITS(N)) if_b ();

    assign if_a.key_valid  = key_valid;
    assign if_a.key_val    = key_val;
    assign if_a.btn_next   = btn_next;
    assign if_a.btn_submit = btn_submit;
    assign if_a.btn_clear  = btn_clear;
    assign if_a.secret     = secret;
    assign if_b.key_valid  = key_valid;
    assign if_b.key_val    = key_val;
    assign if_b.btn_next   = btn_next;
    assign if_b.btn_submit = btn_submit;
    assign if_b.btn_clear  = btn_clear;
    assign if_b.secret     = secret;

    numberle_game_ctrl #(.NUM_DIGITS(N), .MAX_TRIES(7), .SCAN_DIV(SD)) dut_a (
        .clock (clock), .reset (reset), .bus (if_a));
    numberle_game_ctrl #(.NUM_DIGITS(N), .MAX_TRIES(2), .SCAN_DIV(SD)) dut_b (
        .clock (clock), .reset (reset), .bus (if_b));

    int checks = 0;
    int errors = 0;

    int          m_state [2];
    int          m_guess [2][N];
    int          m_sec   [2][N];
    int          m_cur   [2];
    int          m_tries [2];
    int          m_max   [2];
    logic [11:0] m_led   [2];
    logic        m_won   [2];
    logic        m_lost  [2];
    int          e_hex   [2];
    logic        e_dp    [2];
    int          edges = 0;
    int          e_idx = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_new_game(input int k);
        m_state[k] = S_ENTRY;
        for (int i = 0; i < N; i++) m_guess[k][i] = 15;
        m_cur[k]   = 0;
        m_tries[k] = 0;
        m_led[k]   = 12'h000;
        m_won[k]   = 1'b0;
        m_lost[k]  = 1'b0;
    endtask

    task automatic model_display(input int k);
        e_dp[k] = 1'b1;
        case (m_state[k])
            S_ENTRY, S_COMPARE: begin
                e_hex[k] = m_guess[k][e_idx];
                e_dp[k]  = (e_idx == m_cur[k]) ? 1'b0 : 1'b1;
            end
            S_FEEDBACK: e_hex[k] = (e_idx == 0) ? (m_max[k] - m_tries[k]) : 15;
            S_WON:      e_hex[k] = m_sec[k][e_idx];
            default:    e_hex[k] = 14;
        endcase
    endtask

    task automatic model_step(input int k);
        bit blank;
        bit all_eq;
        int g;
        int s;
        if (btn_clear) begin
            model_new_game(k);
        end else begin
            case (m_state[k])
                S_ENTRY: begin
                    blank = 1'b0;
                    for (int i = 0; i < N; i++) if (m_guess[k][i] == 15) blank = 1'b1;
                    if (btn_submit && !blank) m_state[k] = S_COMPARE;
                    if (key_valid && key_val <= 4'd9) m_guess[k][m_cur[k]] = int'(key_val);
                    if (btn_next) m_cur[k] = (m_cur[k] + 1) % N;
                end
                S_COMPARE: begin
                    m_tries[k]++;
                    all_eq = 1'b1;
                    for (int i = 0; i < N; i++) begin
                        g = m_guess[k][i];
                        s = int'(secret[4*i +: 4]);
                        m_sec[k][i]         = s;
                        m_led[k][3*i + 2]   = (g > s);
                        m_led[k][3*i + 1]   = (g == s);
                        m_led[k][3*i]       = (g < s);
                        if (g != s) all_eq = 1'b0;
                    end
                    if (all_eq) begin
                        m_led[k] = 12'hFFF;
                        m_won[k] = 1'b1;
                        m_state[k] = S_WON;
                    end else if (m_tries[k] == m_max[k]) begin
                        m_lost[k] = 1'b1;
                        m_state[k] = S_LOST;
                    end else begin
                        m_state[k] = S_FEEDBACK;
                    end
                end
                S_FEEDBACK: begin
                    if (btn_submit) begin
                        for (int i = 0; i < N; i++) m_guess[k][i] = 15;
                        m_cur[k]   = 0;
                        m_state[k] = S_ENTRY;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Display reflects the pre-edge game state at the post-edge scan position.
    task automatic model_edge();
        if (reset) edges = 0;
        else       edges++;
        e_idx = (edges / SD) % N;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                e_hex[k] = 15;
                e_dp[k]  = 1'b0;
                model_new_game(k);
            end else begin
                model_display(k);
                model_step(k);
            end
        end
    endtask

    task automatic check_inst(input string nm, input int k, input logic [3:0] an,
                              input logic [3:0] hx, input logic d, input logic [11:0] ld,
                              input logic [3:0] tr, input logic w, input logic l);
        logic [3:0] exp_an;
        exp_an = ~(4'b0001 << e_idx);
        check_val({"anode_", nm}, an, exp_an);
        check_val({"hex_", nm}, hx, e_hex[k]);
        check_val({"dp_", nm}, d, e_dp[k]);
        check_val({"led_", nm}, ld, m_led[k]);
        check_val({"tries_", nm}, tr, m_tries[k]);
        check_val({"won_", nm}, w, m_won[k]);
        check_val({"lost_", nm}, l, m_lost[k]);
    endtask

    task automatic cycle(input logic kv, input logic [3:0] kval, input logic nx,
                         input logic sb, input logic cl);
        key_valid  = kv;
        key_val    = kval;
        btn_next   = nx;
        btn_submit = sb;
        btn_clear  = cl;
        @(posedge clock);
        model_edge();
        @(negedge clock);
        key_valid  = 1'b0;
        btn_next   = 1'b0;
        btn_submit = 1'b0;
        btn_clear  = 1'b0;
        check_inst("a", 0, if_a.anode, if_a.hex_out, if_a.dp, if_a.led, if_a.tries_used,
                   if_a.won, if_a.lost);
        check_inst("b", 1, if_b.anode, if_b.hex_out, if_b.dp, if_b.led, if_b.tries_used,
                   if_b.won, if_b.lost);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic key(input logic [3:0] v); cycle(1'b1, v, 1'b0, 1'b0, 1'b0); endtask
    task automatic nxt();    cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0); endtask
    task automatic submit(); cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0); endtask
    task automatic clear();  cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1); endtask

    task automatic wait_pos0();
        idle(1);
        for (int i = 0; i < N * SD + 1 && e_idx != 0; i++) idle(1);
    endtask

    initial begin
        m_max[0] = 7;
        m_max[1] = 2;
        @(negedge clock);
        reset = 1'b1;
        idle(1);
        check_val("rst_anode", if_a.anode, 4'b1110);
        check_val("rst_hex", if_a.hex_out, 4'hF);
        check_val("rst_dp", if_a.dp, 1'b0);
        reset = 1'b0;
        idle(4);
        check_val("scan_pos1", if_a.anode, 4'b1101);
        idle(12);
        check_val("scan_wrap", if_a.anode, 4'b1110);

        // Winning guess 1,2,3,4 against 16'h4321.
        secret = 16'h4321;
        key(4'd1); nxt(); key(4'd2); nxt(); key(4'd3); nxt(); key(4'd4);
        submit();
        idle(1);
        check_val("win_flag", if_a.won, 1'b1);
        check_val("win_led", if_a.led, 12'hFFF);
        check_val("win_tries", if_a.tries_used, 4'd1);
        check_val("win_flag_b", if_b.won, 1'b1);
        idle(N * SD);
        clear();

        // 5555 against 16'h1937, key+next together each time.
        secret = 16'h1937;
        repeat (4) cycle(1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
        submit();
        idle(1);
        check_val("fb_led", if_a.led, 12'h861);
        check_val("fb_tries", if_a.tries_used, 4'd1);
        wait_pos0();
        check_val("fb_left_a", if_a.hex_out, 4'd6);
        check_val("fb_left_b", if_b.hex_out, 4'd1);

        // Second wrong guess exhausts the 2-try instance.
        submit();
        repeat (4) cycle(1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
        submit();
        idle(1);
        check_val("lose_flag_b", if_b.lost, 1'b1);
        check_val("lose_tries_b", if_b.tries_used, 4'd2);
        check_val("nolose_a", if_a.lost, 1'b0);
        idle(2 * SD);
        check_val("lose_hex_b", if_b.hex_out, 4'hE);
        clear();
        idle(1);
        check_val("clr_tries_b", if_b.tries_used, 4'd0);
        check_val("clr_lost_b", if_b.lost, 1'b0);

        // Submit with a blank digit, and an out-of-range key.
        key(4'd7); nxt(); key(4'd8); nxt(); nxt(); key(4'd6);
        submit();
        idle(1);
        check_val("blank_submit", if_a.tries_used, 4'd0);
        nxt();
        cycle(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
        wait_pos0();
        check_val("key_a_ignored", if_a.hex_out, 4'd7);

        // Clear beats submit on a full guess.
        nxt(); nxt(); key(4'd9);
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        idle(2);
        check_val("clr_vs_sub_tries", if_a.tries_used, 4'd0);
        check_val("clr_vs_sub_led", if_a.led, 12'h000);

        // Reset while in COMPARE discards the compare.
        repeat (4) cycle(1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
        submit();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check_val("rst_mid_cmp", if_a.tries_used, 4'd0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                for (int i = 0; i < N; i++) secret[4*i +: 4] = 4'($urandom_range(0, 9));
            end else if ($urandom_range(0, 31) == 0) begin
                for (int i = 0; i < N; i++)
                    secret[4*i +: 4] = (m_guess[0][i] <= 9) ? 4'(m_guess[0][i]) : 4'd0;
            end
            reset = ($urandom_range(0, 999) < 3);
            cycle(1'($urandom_range(0, 99) < 40), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < 15),
                  1'($urandom_range(0, 99) < 2));
            reset = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/numberle_game_ctrl.md
NUMBERLE_GAME_CTRL -- requirements
Module: numberle_game_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of decimal digits per guess and display positions (range 2..8).
REQ-002 Parameter MAX_TRIES, default 7: guesses allowed before loss (range 1..15).
REQ-003 Parameter SCAN_DIV, default 100000: clock cycles each display position stays lit (>=2).
REQ-004 clock  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 key_valid  input  1  one-cycle pulse: key_val holds a new keypad code.
REQ-007 key_val  input  4  keypad code; 0..9 are digits, others ignored.
REQ-008 btn_next  input  1  one-cycle pulse (pre-debounced): advance entry cursor.
REQ-009 btn_submit  input  1  one-cycle pulse: submit guess / acknowledge feedback.
REQ-010 btn_clear  input  1  one-cycle pulse: start new game.
REQ-011 secret  input  4*NUM_DIGITS  BCD target, digit 0 in bits [3:0]; sampled only in COMPARE.
REQ-012 anode  output  NUM_DIGITS  active-low one-hot position enable.
REQ-013 hex_out  output  4  code for the enabled position.
REQ-014 dp  output  1  active-low decimal point for the enabled position.
REQ-015 led  output  3*NUM_DIGITS  per-digit feedback: bit 3i+2 guess high, 3i+1 equal, 3i guess low.
REQ-016 tries_used  output  4  guesses submitted this game.
REQ-017 won, lost  output  1 each  game result flags.

Function
REQ-018 FSM states ENTRY, COMPARE, FEEDBACK, WON, LOST; reset state ENTRY.
REQ-019 ENTRY: key_valid with key_val<=9 writes guess digit[cursor]; key_val>9 ignored.
REQ-020 ENTRY: btn_next advances cursor; NUM_DIGITS-1 wraps to 0.
REQ-021 Same-cycle key_valid and btn_next: write current cursor digit, then advance.
REQ-022 ENTRY: btn_submit moves to COMPARE only if no guess digit equals BLANK (4'hF); otherwise ignored.
REQ-023 COMPARE lasts exactly one cycle: latch led from per-digit compare, tries_used+1.
REQ-024 COMPARE exit: all digits equal -> WON; else tries_used(new)==MAX_TRIES -> LOST; else FEEDBACK.
REQ-025 led valid one cycle after COMPARE entry; holds until next COMPARE, btn_clear or reset.
REQ-026 FEEDBACK: btn_submit -> ENTRY, guess digits all BLANK, cursor 0, led kept.
REQ-027 WON: led all ones, won=1; LOST: lost=1, led kept; both hold until btn_clear or reset.
REQ-028 btn_clear in any state -> ENTRY, guess BLANK, cursor 0, tries_used 0, led 0, won/lost 0; priority over every other input same cycle.
REQ-029 btn_submit in COMPARE, key_valid/btn_next outside ENTRY: ignored.
REQ-030 Scan: counter counts 0..SCAN_DIV-1; on wrap, position index increments, NUM_DIGITS-1 wraps to 0; runs in all states.
REQ-031 Display ENTRY: hex_out=guess digit[index], dp=0 only at cursor position.
REQ-032 Display FEEDBACK: position 0 shows MAX_TRIES-tries_used, others BLANK; dp=1.
REQ-033 Display WON: secret digits; LOST: 4'hE on all positions; COMPARE: same as ENTRY.
REQ-034 anode, hex_out, dp registered; change only on scan position change or state/data update; no glitching.

Reset
REQ-035 On reset: state ENTRY, guess all BLANK, cursor 0, tries_used 0, led 0, won 0, lost 0, scan counter 0, index 0.
REQ-036 Reset outputs one cycle after assertion: anode = all ones except bit 0 low, hex_out 4'hF, dp 0 (cursor at 0).
REQ-037 Reset mid-COMPARE discards the compare; tries_used stays 0.

Structure
REQ-038 Package numberle_pkg holds state enum, BLANK=4'hF, LOST_CODE=4'hE, digit width 4.
REQ-039 Scan counter/index/anode generation in one sub-module numberle_scan_mux, parametrised by NUM_DIGITS and SCAN_DIV.

Verification
REQ-040 N=4, SCAN_DIV=4: reset -> anode 4'b1110, hex_out F, dp 0; index advances every 4 cycles, wraps 3->0.
REQ-041 Keys 1,btn_next,2,btn_next,3,btn_next,4, submit, secret 16'h4321 -> won=1, led 12'hFFF, tries_used 1.
REQ-042 Guess 5,5,5,5 vs 16'h1937 -> led digit0 low, digit1 high, digit2 low, digit3 high; state FEEDBACK, position 0 shows 6.
REQ-043 Submit with digit 2 BLANK -> stays ENTRY, tries_used unchanged; key_val 4'hA ignored.
REQ-044 MAX_TRIES=2, two wrong guesses -> lost=1, all positions show E; btn_clear -> ENTRY, tries_used 0.
REQ-045 btn_clear and btn_submit same cycle in ENTRY with full guess -> ENTRY cleared, no COMPARE.
